// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// dm_arbiter : two-port (CPU / DMA-debug) arbiter for a 1024 x 32 data memory.
// Optional macro DM_ARB_FIXED_PRIO_EN: port 0 wins every tie (no round-robin).
// Revision 1.0
// ============================================================================
module dm_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0,
    input  logic [9:0]  addr0,
    input  logic [1:0]  wr0,
    input  logic [2:0]  read0,
    input  logic [31:0] din0,

    input  logic        req1,
    input  logic [9:0]  addr1,
    input  logic [1:0]  wr1,
    input  logic [2:0]  read1,
    input  logic [31:0] din1,

    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata,

    output logic [9:0]  mem_addr,
    output logic [1:0]  mem_wr,
    output logic [2:0]  mem_read,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_port;
    logic [9:0]  r_addr;
    logic [1:0]  r_wr;
    logic [2:0]  r_read;
    logic [31:0] r_din;

    logic        w_any_req;
    logic        w_winner;
    logic        w_accept;

    assign w_any_req = req0 | req1;
    assign w_accept  = (r_state == S_IDLE) && w_any_req;

`ifndef DM_ARB_FIXED_PRIO_EN
    // Last-served port; resets to port 1 so port 0 takes the first tie.
    logic        r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_winner;
        end
    end
`endif

    always_comb begin
        w_winner = 1'b0;
        if (req0 && req1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
            w_winner = 1'b0;
`else
            w_winner = ~r_last;
`endif
        end else if (req1) begin
            w_winner = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_port  <= 1'b0;
            r_addr  <= 10'd0;
            r_wr    <= 2'b00;
            r_read  <= 3'b000;
            r_din   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_port <= w_winner;
                r_addr <= w_winner ? addr1 : addr0;
                r_wr   <= w_winner ? wr1   : wr0;
                r_read <= w_winner ? read1 : read0;
                r_din  <= w_winner ? din1  : din0;
            end
        end
    end

    // Memory strobes are decoded from the state so an async reset in ISSUE
    // withdraws a pending write before the memory can sample it.
    always_comb begin
        w_state_nxt = r_state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        rdata       = 32'd0;
        mem_wr      = 2'b00;
        mem_read    = 3'b000;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_RESP;
                gnt0        = ~r_port;
                gnt1        = r_port;
                mem_wr      = r_wr;
                mem_read    = r_read;
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                done0       = ~r_port;
                done1       = r_port;
                rdata       = mem_dout;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_addr = r_addr;
    assign mem_din  = r_din;

endmodule
`default_nettype wire
